// File: rtl/uart_pkg.sv
// Shared definitions for the 32-bit word UART transmitter: sequencer state
// encoding, frame geometry and the MSB-first byte selection helper.
package uart_pkg;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_FETCH = 5'b00010,
      ST_LATCH = 5'b00100,
      ST_SEND  = 5'b01000,
      ST_NEXT  = 5'b10000
   } word_state_t;

   localparam int FRAME_BITS     = 10;
   localparam int BYTES_PER_WORD = 4;

   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   // Byte 0 is the most significant byte, so words go out big-endian on the line.
   function automatic logic [7:0] select_byte(input logic [31:0] word,
                                              input logic [1:0]  idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = word[31:24];
         2'd1:    b = word[23:16];
         2'd2:    b = word[15:8];
         default: b = word[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_word_tx_if.sv
// FIFO-side handshake and serial outputs of the word transmitter.
// master = the transmitter, slave = the surrounding FIFO/control logic.
interface uart_word_tx_if;

   logic        uart_en;
   logic        fifo_empty;
   logic [31:0] fifo_dout;
   logic        fifo_rd_en;
   logic        tx;
   logic        busy;
   logic        word_done;

   modport master (
      input  uart_en,
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd_en,
      output tx,
      output busy,
      output word_done
   );

   modport slave (
      output uart_en,
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd_en,
      input  tx,
      input  busy,
      input  word_done
   );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, one stop bit,
// each held for CLKS_PER_BIT clocks. tx is registered and idles high.
module uart_tx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] DONE_CNT = 16'(CLKS_PER_BIT - 3);
   localparam logic [3:0]  STOP_IDX = 4'(FRAME_BITS - 1);

   logic        active;
   logic [15:0] clk_cnt;
   logic [3:0]  bit_idx;
   logic [8:0]  shreg;

   // done fires one cycle before the stop bit's final clock so the sequencer
   // can present the next byte's start exactly as the stop bit ends.
   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= 1'b0;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '1;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= active && (bit_idx == STOP_IDX) && (clk_cnt == DONE_CNT);
         if (start) begin
            active  <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, data};
            tx      <= 1'b0;
         end else if (active) begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt <= '0;
               if (bit_idx == STOP_IDX) begin
                  active  <= 1'b0;
                  bit_idx <= '0;
                  tx      <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 4'd1;
                  tx      <= shreg[0];
                  shreg   <= {1'b1, shreg[8:1]};
               end
            end else begin
               clk_cnt <= clk_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// Pulls 32-bit words from an upstream FIFO and sends each as four 8N1 bytes,
// MSB byte first, with no gap between the bytes of a word.
module uart_word_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic           clk,
   input  logic           rst,
   uart_word_tx_if.master bus
);

   word_state_t state;
   word_state_t state_nx;

   logic [31:0] word_q;
   logic [1:0]  byte_idx;

   logic        ser_start;
   logic [7:0]  ser_data;
   logic        ser_tx;
   logic        ser_done;

   logic        fifo_rd_en_q;
   logic        busy_q;
   logic        word_done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // The first byte is taken straight from fifo_dout in LATCH so its start bit
   // lands in the very next cycle, while the word register is being loaded.
   always_comb begin
      state_nx  = state;
      ser_start = 1'b0;
      ser_data  = select_byte(word_q, byte_idx);
      case (state)
         ST_IDLE: begin
            if (bus.uart_en && !bus.fifo_empty) begin
               state_nx = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_nx = ST_LATCH;
         end
         ST_LATCH: begin
            ser_start = 1'b1;
            ser_data  = bus.fifo_dout[31:24];
            state_nx  = ST_SEND;
         end
         ST_SEND: begin
            if (ser_done) begin
               state_nx = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (byte_idx != LAST_BYTE) begin
               ser_start = 1'b1;
               ser_data  = select_byte(word_q, byte_idx + 2'd1);
               state_nx  = ST_SEND;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Outputs come from flops fed by the next state, so they line up with the
   // state they describe without any combinational path to the ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q       <= '0;
         byte_idx     <= '0;
         fifo_rd_en_q <= 1'b0;
         busy_q       <= 1'b0;
         word_done_q  <= 1'b0;
      end else begin
         if (state == ST_LATCH) begin
            word_q   <= bus.fifo_dout;
            byte_idx <= '0;
         end else if ((state == ST_NEXT) && (byte_idx != LAST_BYTE)) begin
            byte_idx <= byte_idx + 2'd1;
         end
         fifo_rd_en_q <= (state_nx == ST_FETCH);
         busy_q       <= (state_nx != ST_IDLE);
         word_done_q  <= (state == ST_NEXT) && (byte_idx == LAST_BYTE);
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clk  (clk),
      .rst  (rst),
      .start(ser_start),
      .data (ser_data),
      .tx   (ser_tx),
      .done (ser_done)
   );

   assign bus.fifo_rd_en = fifo_rd_en_q;
   assign bus.tx         = ser_tx;
   assign bus.busy       = busy_q;
   assign bus.word_done  = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx at 4 clocks per bit: a small FIFO model,
// a per-cycle log of the line, and frame decoding against hand-computed bytes.
module tb_uart_word_tx;

   logic clk;
   logic rst;

   uart_word_tx_if bus_if ();

   uart_word_tx #(
      .CLKS_PER_BIT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] fifo_q[$];
   logic        tx_hist[$];
   logic        busy_hist[$];
   int          rd_idx[$];
   int          wd_idx[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // FIFO model: pops on the strobe seen mid-cycle, data valid from then on.
   initial begin
      bus_if.fifo_empty = 1'b1;
      bus_if.fifo_dout  = '0;
      forever begin
         @(negedge clk);
         if (bus_if.fifo_rd_en) begin
            if (fifo_q.size() > 0) bus_if.fifo_dout = fifo_q.pop_front();
            else                   bus_if.fifo_dout = 'x;
         end
         bus_if.fifo_empty = (fifo_q.size() == 0);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         tx_hist.push_back(bus_if.tx);
         busy_hist.push_back(bus_if.busy);
         if (bus_if.fifo_rd_en) rd_idx.push_back(tx_hist.size() - 1);
         if (bus_if.word_done)  wd_idx.push_back(tx_hist.size() - 1);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [31:0] w);
      fifo_q.push_back(w);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic logic getTx(input int i);
      if (i >= 0 && i < tx_hist.size()) return tx_hist[i];
      return 1'bx;
   endfunction

   function automatic logic getBusy(input int i);
      if (i >= 0 && i < busy_hist.size()) return busy_hist[i];
      return 1'bx;
   endfunction

   function automatic int pick(input int q[$], input int k);
      if (k >= 0 && k < q.size()) return q[k];
      return -1;
   endfunction

   // Mid-bit samples of one frame; bit 0 is the start bit, bit 9 the stop bit.
   function automatic logic [9:0] decodeFrame(input int s);
      logic [9:0] fr;
      for (int k = 0; k < 10; k++) fr[k] = getTx(s + 4 * k + 2);
      return fr;
   endfunction

   function automatic int findFall(input int from);
      for (int i = (from < 1) ? 1 : from; i < tx_hist.size(); i++) begin
         if (tx_hist[i] == 1'b0 && tx_hist[i-1] == 1'b1) return i;
      end
      return -1;
   endfunction

   function automatic int onesRun(input int s);
      int n = 0;
      while (n < 20 && getTx(s + n) === 1'b1) n++;
      return n;
   endfunction

   function automatic int countTxZeros(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (getTx(i) !== 1'b1) n++;
      return n;
   endfunction

   function automatic int countBusy(input int a, input int b);
      int n = 0;
      for (int i = a; i <= b; i++) if (getBusy(i) !== 1'b0) n++;
      return n;
   endfunction

   task automatic checkWord(input string tag, input int s, input logic [31:0] w);
      for (int j = 0; j < 4; j++) begin
         logic [7:0] b;
         b = w[8*(3-j) +: 8];
         checkOutput($sformatf("%s_byte%0d", tag, j), 32'(decodeFrame(s + 40 * j)),
                     32'({1'b1, b, 1'b0}));
      end
   endtask

   task automatic waitFall(input string tag, output int idx);
      idx = -1;
      for (int n = 0; n < 60 && idx < 0; n++) begin
         tick(1);
         if (tx_hist[$] == 1'b0) idx = tx_hist.size() - 1;
      end
      checkOutput({tag, "_start_seen"}, 32'(idx >= 0), 32'd1);
   endtask

   initial begin
      int base;
      int rdb;
      int wdb;
      int f;
      int f2;

      rst = 1'b1;
      bus_if.uart_en = 1'b0;
      tick(3);
      checkOutput("reset_tx", 32'(bus_if.tx), 32'd1);
      checkOutput("reset_busy", 32'(bus_if.busy), 32'd0);
      checkOutput("reset_rd_en", 32'(bus_if.fifo_rd_en), 32'd0);
      checkOutput("reset_word_done", 32'(bus_if.word_done), 32'd0);
      rst = 1'b0;
      tick(2);

      // Single word: byte order, one strobe, fixed latencies around the frame.
      base = tx_hist.size(); rdb = rd_idx.size(); wdb = wd_idx.size();
      applyStimulus(32'h12345678);
      bus_if.uart_en = 1'b1;
      tick(200);
      f = findFall(base);
      checkWord("single", f, 32'h12345678);
      checkOutput("single_rd_count", 32'(rd_idx.size() - rdb), 32'd1);
      checkOutput("single_rd_pos", 32'(pick(rd_idx, rdb)), 32'(f - 2));
      checkOutput("single_word_done_pos", 32'(pick(wd_idx, wdb)), 32'(f + 160));

      // Three queued words back to back: 160 cycles each plus a 3-cycle gap.
      base = tx_hist.size(); rdb = rd_idx.size(); wdb = wd_idx.size();
      applyStimulus(32'h00000001);
      applyStimulus(32'hFFFFFFFF);
      applyStimulus(32'h80000000);
      tick(520);
      f = findFall(base);
      checkWord("burst_w0", f, 32'h00000001);
      checkWord("burst_w1", f + 163, 32'hFFFFFFFF);
      checkWord("burst_w2", f + 326, 32'h80000000);
      checkOutput("burst_gap0", 32'(onesRun(f + 160)), 32'd3);
      checkOutput("burst_gap1", 32'(onesRun(f + 323)), 32'd3);
      checkOutput("burst_rd_count", 32'(rd_idx.size() - rdb), 32'd3);
      checkOutput("burst_word_done_count", 32'(wd_idx.size() - wdb), 32'd3);

      // Enabled but empty: nothing may be fetched or sent.
      base = tx_hist.size(); rdb = rd_idx.size();
      tick(100);
      checkOutput("empty_rd_count", 32'(rd_idx.size() - rdb), 32'd0);
      checkOutput("empty_tx_low_cycles", 32'(countTxZeros(base, base + 99)), 32'd0);
      checkOutput("empty_busy_cycles", 32'(countBusy(base, base + 99)), 32'd0);

      // Enable dropped 20 cycles into a word: word completes, second word waits.
      rdb = rd_idx.size(); wdb = wd_idx.size();
      applyStimulus(32'hA5C33C5A);
      applyStimulus(32'hDEAD00EF);
      waitFall("drop", f);
      tick(20);
      bus_if.uart_en = 1'b0;
      tick(250);
      checkWord("drop", f, 32'hA5C33C5A);
      checkOutput("drop_rd_count", 32'(rd_idx.size() - rdb), 32'd1);
      checkOutput("drop_word_done_pos", 32'(pick(wd_idx, wdb)), 32'(f + 160));
      checkOutput("drop_busy_last_stop", 32'(getBusy(f + 159)), 32'd1);
      checkOutput("drop_busy_after", 32'(getBusy(f + 160)), 32'd0);
      checkOutput("drop_tx_low_after", 32'(countTxZeros(f + 160, f + 260)), 32'd0);

      // Reset during data bit 3 of byte 2 of 0xDEAD00EF, then the next word runs.
      rdb = rd_idx.size();
      applyStimulus(32'h0F1E2D3C);
      bus_if.uart_en = 1'b1;
      waitFall("abort", f);
      tick(97);
      checkOutput("abort_tx_before_rst", 32'(bus_if.tx), 32'd0);
      rst = 1'b1;
      tick(1);
      checkOutput("abort_tx", 32'(bus_if.tx), 32'd1);
      checkOutput("abort_busy", 32'(bus_if.busy), 32'd0);
      rst = 1'b0;
      tick(200);
      f2 = findFall(f + 98);
      checkWord("after_abort", f2, 32'h0F1E2D3C);
      checkOutput("abort_rd_count", 32'(rd_idx.size() - rdb), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
